// File: rtl/vec_store_unit.sv
// Serial store path: captures five vector lanes and writes the enabled
// lanes to data memory one word per accepted handshake.
module vec_store_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int STRIDE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DATA_W-1:0] lane_a,
   input  logic [DATA_W-1:0] lane_b,
   input  logic [DATA_W-1:0] lane_c,
   input  logic [DATA_W-1:0] lane_d,
   input  logic [DATA_W-1:0] lane_e,
   input  logic [4:0]        lane_mask,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic [2:0]        words_written
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t                 state_q;
   logic [4:0][DATA_W-1:0] lane_q;
   logic [4:0][DATA_W-1:0] lanes_in;
   logic [ADDR_W-1:0]      base_q;
   logic [4:0]             mask_q;
   logic [2:0]             ptr_q;
   logic                   we_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic                   busy_q;
   logic                   done_q;
   logic [2:0]             words_q;

   logic [4:0]             mask_d;
   logic [2:0]             ptr_d;
   logic [2:0]             start_ptr;

   function automatic logic [2:0] lowest(input logic [4:0] m);
      lowest = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (m[i]) lowest = 3'(i);
      end
   endfunction

   function automatic logic [ADDR_W-1:0] lane_addr(
      input logic [ADDR_W-1:0] b,
      input logic [2:0]        idx
   );
      lane_addr = b + ADDR_W'(STRIDE) * ADDR_W'(idx);
   endfunction

   assign lanes_in  = {lane_e, lane_d, lane_c, lane_b, lane_a};
   assign start_ptr = lowest(lane_mask);

   // Masked-off lanes are skipped by jumping straight to the next set bit.
   always_comb begin
      mask_d = mask_q & ~(5'b00001 << ptr_q);
      ptr_d  = lowest(mask_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         lane_q  <= '0;
         base_q  <= '0;
         mask_q  <= '0;
         ptr_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         words_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  lane_q  <= lanes_in;
                  base_q  <= base_addr;
                  mask_q  <= lane_mask;
                  words_q <= '0;
                  busy_q  <= 1'b1;
                  if (|lane_mask) begin
                     state_q <= WRITE;
                     ptr_q   <= start_ptr;
                     we_q    <= 1'b1;
                     addr_q  <= lane_addr(base_addr, start_ptr);
                     wdata_q <= lanes_in[start_ptr];
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  words_q <= words_q + 3'd1;
                  mask_q  <= mask_d;
                  if (|mask_d) begin
                     ptr_q   <= ptr_d;
                     addr_q  <= lane_addr(base_q, ptr_d);
                     wdata_q <= lane_q[ptr_d];
                  end else begin
                     state_q <= DONE;
                     we_q    <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign words_written = words_q;

endmodule

// File: tb/tb_vec_store_unit.sv
// Scoreboard bench for vec_store_unit: expected writes are queued at
// stimulus time and retired by a negedge monitor on each accepted write.
module tb_vec_store_unit;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [31:0] lane_a = '0, lane_b = '0, lane_c = '0;
   logic [31:0] lane_d = '0, lane_e = '0;
   logic [4:0]  lane_mask = '0;
   logic        mem_ready = 1'b1;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic [2:0]  words_written;

   int total = 0;
   int bad = 0;
   int nwrites = 0;
   int stall_cnt = 0;
   int busy_cnt = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] hold_a = '0;
   logic [31:0] hold_d = '0;
   wr_t q[$];

   vec_store_unit #(.DATA_W(32), .ADDR_W(32), .STRIDE(4)) dut (
      .clk(clk), .reset(reset), .start(start),
      .base_addr(base_addr),
      .lane_a(lane_a), .lane_b(lane_b), .lane_c(lane_c),
      .lane_d(lane_d), .lane_e(lane_e),
      .lane_mask(lane_mask),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready),
      .busy(busy), .done(done), .words_written(words_written)
   );

   always #5 clk = ~clk;

   // Write monitor: scoreboard pop, stall stability, we-outside-WRITE.
   always @(negedge clk) begin
      if (reset) begin
         if (mem_we) begin
            total++;
            if (!busy || done) begin
               bad++;
               $display("FAIL we_state: busy=%0b done=%0b required busy=1 done=0",
                        busy, done);
            end
         end
         if (stall_prev && mem_we) begin
            total++;
            if (mem_addr !== hold_a || mem_wdata !== hold_d) begin
               bad++;
               $display("FAIL stall_hold: got %h/%h required %h/%h",
                        mem_addr, mem_wdata, hold_a, hold_d);
            end
         end
         if (mem_we && mem_ready) begin
            wr_t e;
            total++;
            nwrites++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write: got %h/%h required none",
                        mem_addr, mem_wdata);
            end else begin
               e = q.pop_front();
               if (mem_addr !== e.a || mem_wdata !== e.d) begin
                  bad++;
                  $display("FAIL write: got %h/%h required %h/%h",
                           mem_addr, mem_wdata, e.a, e.d);
               end
            end
         end
         stall_prev = mem_we && !mem_ready;
         if (stall_prev) stall_cnt++;
         hold_a = mem_addr;
         hold_d = mem_wdata;
         if (busy) busy_cnt++;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic push_exp(input logic [31:0] b, input logic [4:0] m,
                           input logic [31:0] la, input logic [31:0] lb,
                           input logic [31:0] lc, input logic [31:0] ld,
                           input logic [31:0] le);
      logic [31:0] lv[5];
      lv = '{la, lb, lc, ld, le};
      for (int i = 0; i < 5; i++) begin
         if (m[i]) q.push_back({b + 32'(4 * i), lv[i]});
      end
   endtask

   task automatic run_op(input logic [31:0] b, input logic [4:0] m,
                         input logic [31:0] la, input logic [31:0] lb,
                         input logic [31:0] lc, input logic [31:0] ld,
                         input logic [31:0] le,
                         input int sfrom, input int slen,
                         output int done_cyc, output int first_we,
                         output int writes);
      int w0;
      push_exp(b, m, la, lb, lc, ld, le);
      w0 = nwrites;
      base_addr = b; lane_mask = m;
      lane_a = la; lane_b = lb; lane_c = lc; lane_d = ld; lane_e = le;
      mem_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      done_cyc = -1;
      first_we = -1;
      for (int n = 1; n <= 40; n++) begin
         mem_ready = !(n >= sfrom && n < sfrom + slen);
         if (mem_we && first_we < 0) first_we = n;
         if (done) begin
            done_cyc = n;
            break;
         end
         @(posedge clk); #1;
      end
      writes = nwrites - w0;
      mem_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      total++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl: we=%b busy=%b done=%b required 0",
                  mem_we, busy, done);
      end
      total++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_bus: got %h/%h required 0/0",
                  mem_addr, mem_wdata);
      end
      total++;
      if (words_written !== 3'd0) begin
         bad++;
         $display("FAIL reset_ww: got %0d required 0", words_written);
      end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full();
      int dc, fw, wr, b0;
      b0 = busy_cnt;
      run_op(32'h100, 5'b11111, 1, 2, 3, 4, 5, 99, 0, dc, fw, wr);
      @(posedge clk); #1;
      total++;
      if (fw !== 1) begin
         bad++; $display("FAIL full_first_we: got %0d required 1", fw);
      end
      total++;
      if (dc !== 6) begin
         bad++; $display("FAIL full_done_cyc: got %0d required 6", dc);
      end
      total++;
      if (wr !== 5 || q.size() !== 0) begin
         bad++;
         $display("FAIL full_writes: got %0d left %0d required 5 left 0",
                  wr, q.size());
      end
      total++;
      if (busy_cnt - b0 !== 6) begin
         bad++;
         $display("FAIL full_busy: got %0d required 6", busy_cnt - b0);
      end
      total++;
      if (words_written !== 3'd5 || busy !== 1'b0) begin
         bad++;
         $display("FAIL full_ww: got %0d busy %b required 5 busy 0",
                  words_written, busy);
      end
   endtask

   task automatic test_sparse();
      int dc, fw, wr;
      run_op(32'h200, 5'b10100, 32'h11, 32'h22, 32'hAA, 32'h44, 32'hEE,
             99, 0, dc, fw, wr);
      @(posedge clk); #1;
      total++;
      if (fw !== 1 || dc !== 3) begin
         bad++;
         $display("FAIL sparse_timing: first %0d done %0d required 1 3", fw, dc);
      end
      total++;
      if (wr !== 2 || q.size() !== 0 || words_written !== 3'd2) begin
         bad++;
         $display("FAIL sparse_count: got %0d ww %0d required 2 2",
                  wr, words_written);
      end
   endtask

   task automatic test_backpressure();
      int dc, fw, wr, s0;
      s0 = stall_cnt;
      run_op(32'h300, 5'b11111, 32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0,
             2, 3, dc, fw, wr);
      @(posedge clk); #1;
      total++;
      if (dc !== 9) begin
         bad++; $display("FAIL bp_done_cyc: got %0d required 9", dc);
      end
      total++;
      if (stall_cnt - s0 !== 3) begin
         bad++;
         $display("FAIL bp_stalls: got %0d required 3", stall_cnt - s0);
      end
      total++;
      if (wr !== 5 || q.size() !== 0 || words_written !== 3'd5) begin
         bad++;
         $display("FAIL bp_count: got %0d ww %0d required 5 5",
                  wr, words_written);
      end
   endtask

   task automatic test_zero_mask();
      int dc, fw, wr;
      run_op(32'h400, 5'b00000, 7, 7, 7, 7, 7, 99, 0, dc, fw, wr);
      total++;
      if (dc !== 1 || fw !== -1 || wr !== 0) begin
         bad++;
         $display("FAIL zero_mask: done %0d we %0d wr %0d required 1 -1 0",
                  dc, fw, wr);
      end
      @(posedge clk); #1;
      total++;
      if (words_written !== 3'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL zero_ww: got %0d busy %b required 0 0",
                  words_written, busy);
      end
   endtask

   task automatic test_ignore_start();
      int dc, w0, extra;
      push_exp(32'h700, 5'b11111, 11, 12, 13, 14, 15);
      w0 = nwrites;
      base_addr = 32'h700; lane_mask = 5'b11111;
      lane_a = 11; lane_b = 12; lane_c = 13; lane_d = 14; lane_e = 15;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = 32'h7700; lane_mask = 5'b00011;
      lane_a = 91; lane_b = 92; lane_c = 93; lane_d = 94; lane_e = 95;
      dc = -1;
      for (int n = 1; n <= 40; n++) begin
         start = (n == 3);
         if (done) begin
            dc = n;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      total++;
      if (dc !== 6 || nwrites - w0 !== 5 || q.size() !== 0) begin
         bad++;
         $display("FAIL ignore_op: done %0d wr %0d required 6 5",
                  dc, nwrites - w0);
      end
      extra = 0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (mem_we || busy) extra++;
      end
      total++;
      if (extra !== 0 || words_written !== 3'd5) begin
         bad++;
         $display("FAIL ignore_idle: active %0d ww %0d required 0 5",
                  extra, words_written);
      end
   endtask

   task automatic test_address_wrap();
      int dc, fw, wr;
      q.push_back({32'hFFFFFFF8, 32'h1});
      q.push_back({32'hFFFFFFFC, 32'h2});
      q.push_back({32'h00000000, 32'h3});
      q.push_back({32'h00000004, 32'h4});
      q.push_back({32'h00000008, 32'h5});
      // run_op would queue its own copy; use an empty mask model here.
      base_addr = 32'hFFFFFFF8; lane_mask = 5'b11111;
      lane_a = 1; lane_b = 2; lane_c = 3; lane_d = 4; lane_e = 5;
      wr = nwrites;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dc = -1;
      for (int n = 1; n <= 40; n++) begin
         if (done) begin
            dc = n;
            break;
         end
         @(posedge clk); #1;
      end
      fw = nwrites - wr;
      total++;
      if (dc !== 6 || fw !== 5 || q.size() !== 0) begin
         bad++;
         $display("FAIL wrap: done %0d wr %0d left %0d required 6 5 0",
                  dc, fw, q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int dc, fw, wr, w0, act;
      bit hit;
      push_exp(32'h800, 5'b11111, 21, 22, 23, 24, 25);
      w0 = nwrites;
      base_addr = 32'h800; lane_mask = 5'b11111;
      lane_a = 21; lane_b = 22; lane_c = 23; lane_d = 24; lane_e = 25;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (nwrites - w0 == 2) begin
            hit = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      total++;
      if (!hit) begin
         bad++; $display("FAIL rst_mid_wait: got timeout required 2 writes");
      end
      #1 reset = 1'b0;
      #1;
      q.delete();
      total++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
          words_written !== 3'd0) begin
         bad++;
         $display("FAIL rst_mid_out: we %b busy %b addr %h ww %0d required 0",
                  mem_we, busy, mem_addr, words_written);
      end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      act = 0;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         if (mem_we || busy || done) act++;
      end
      total++;
      if (act !== 0) begin
         bad++; $display("FAIL rst_mid_idle: got %0d active required 0", act);
      end
      run_op(32'h900, 5'b00001, 32'h5A, 1, 2, 3, 4, 99, 0, dc, fw, wr);
      total++;
      if (dc !== 2 || wr !== 1 || q.size() !== 0) begin
         bad++;
         $display("FAIL rst_recover: done %0d wr %0d required 2 1", dc, wr);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_full();
      test_sparse();
      test_backpressure();
      test_zero_mask();
      test_ignore_start();
      test_address_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
